// File: rtl/tk1_pkg.sv
// Shared definitions for the SPI flash command sequencer: register map,
// STATUS bit positions, FSM encodings and byte-ordering helpers.
package tk1_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 8;
  localparam int unsigned CMD_W      = 9;
  localparam int unsigned FADDR_W    = 24;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned BYTE_W     = 8;

  localparam logic [REG_ADDR_W-1:0] REG_CTRL    = 8'h00;
  localparam logic [REG_ADDR_W-1:0] REG_STATUS  = 8'h01;
  localparam logic [REG_ADDR_W-1:0] REG_CMD     = 8'h02;
  localparam logic [REG_ADDR_W-1:0] REG_ADDR    = 8'h03;
  localparam logic [REG_ADDR_W-1:0] REG_LEN     = 8'h04;
  localparam logic [REG_ADDR_W-1:0] REG_RX_BASE = 8'h10;

  localparam int unsigned ST_BUSY_BIT = 0;
  localparam int unsigned ST_DONE_BIT = 1;
  localparam int unsigned ST_ERR_BIT  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_OPCODE, S_ADDR2, S_ADDR1, S_ADDR0, S_READ, S_CS_HOLD
  } state_t;

  // Per-byte handshake: start pulse, ignored cycle, wait for engine idle
  typedef enum logic [1:0] {
    PH_PULSE, PH_SKIP, PH_WAIT
  } phase_t;

  // State that follows a completed byte
  function automatic state_t next_byte_state(state_t st, logic addr_en, logic more_read);
    case (st)
      S_OPCODE: next_byte_state = addr_en ? S_ADDR2 : (more_read ? S_READ : S_CS_HOLD);
      S_ADDR2:  next_byte_state = S_ADDR1;
      S_ADDR1:  next_byte_state = S_ADDR0;
      S_ADDR0:  next_byte_state = more_read ? S_READ : S_CS_HOLD;
      S_READ:   next_byte_state = more_read ? S_READ : S_CS_HOLD;
      default:  next_byte_state = S_CS_HOLD;
    endcase
  endfunction

  function automatic logic [BYTE_W-1:0] tx_byte(state_t st, logic [BYTE_W-1:0] opcode,
                                                logic [FADDR_W-1:0] faddr);
    case (st)
      S_OPCODE: tx_byte = opcode;
      S_ADDR2:  tx_byte = faddr[23:16];
      S_ADDR1:  tx_byte = faddr[15:8];
      S_ADDR0:  tx_byte = faddr[7:0];
      default:  tx_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_seq.sv
// SPI flash command sequencer: register-programmed opcode/address/read
// transactions driven through an external SPI byte engine.
module spi_flash_seq
  import tk1_pkg::*;
#(
  parameter int unsigned BUF_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fw_app_mode,
  input  logic                  cs,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]     write_data,
  output logic [DATA_W-1:0]     read_data,
  output logic                  ready,
  output logic                  spi_start,
  output logic [BYTE_W-1:0]     spi_tx_data,
  input  logic [BYTE_W-1:0]     spi_rx_data,
  input  logic                  spi_ready,
  output logic                  spi_cs
);

  localparam int unsigned MAX_LEN = 4 * BUF_WORDS;

  state_t               r_state, w_state, w_nxt;
  phase_t               r_phase, w_phase;
  logic                 r_spi_cs, w_spi_cs;
  logic                 r_spi_start, w_spi_start;
  logic [BYTE_W-1:0]    r_spi_tx, w_spi_tx;
  logic                 r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic [CMD_W-1:0]     r_cmd, w_cmd;
  logic [FADDR_W-1:0]   r_addr, w_addr;
  logic [LEN_W-1:0]     r_len, w_len;
  logic [CNT_W-1:0]     r_cnt, w_cnt, w_cnt_inc;
  logic [DATA_W-1:0]    r_rx [BUF_WORDS];
  logic [DATA_W-1:0]    w_rx [BUF_WORDS];
  logic                 w_cfg_wr, w_start, w_more;

  // Busy is the registered flag, so a start landing as busy falls is dropped
  assign w_cfg_wr  = cs && we && !fw_app_mode && !r_busy;
  assign w_start   = w_cfg_wr && (address == REG_CTRL) && write_data[0];
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_spi_cs    = r_spi_cs;
    w_spi_start = 1'b0;
    w_spi_tx    = r_spi_tx;
    w_busy      = r_busy;
    w_done      = r_done;
    w_err       = r_err;
    w_cmd       = r_cmd;
    w_addr      = r_addr;
    w_len       = r_len;
    w_cnt       = r_cnt;
    w_rx        = r_rx;
    w_nxt       = S_CS_HOLD;
    w_more      = (r_state == S_READ) ? (w_cnt_inc != r_len) : (r_len != '0);

    if (w_cfg_wr) begin
      case (address)
        REG_CMD:  w_cmd  = write_data[CMD_W-1:0];
        REG_ADDR: w_addr = write_data[FADDR_W-1:0];
        REG_LEN:  w_len  = write_data[LEN_W-1:0];
        default: ;
      endcase
    end

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (32'(r_len) > MAX_LEN) begin
            w_err  = 1'b1;
            w_done = 1'b1;
          end else begin
            for (int i = 0; i < int'(BUF_WORDS); i++) w_rx[i] = '0;
            w_done   = 1'b0;
            w_err    = 1'b0;
            w_busy   = 1'b1;
            w_cnt    = '0;
            w_spi_cs = 1'b0;
            w_state  = S_CS_SETUP;
          end
        end
      end
      S_CS_SETUP: begin
        if (spi_ready) begin
          w_state     = S_OPCODE;
          w_phase     = PH_PULSE;
          w_spi_start = 1'b1;
          w_spi_tx    = tx_byte(S_OPCODE, r_cmd[7:0], r_addr);
        end
      end
      S_OPCODE, S_ADDR2, S_ADDR1, S_ADDR0, S_READ: begin
        case (r_phase)
          PH_PULSE: w_phase = PH_SKIP;
          PH_SKIP:  w_phase = PH_WAIT;
          default: begin
            if (spi_ready) begin
              if (r_state == S_READ) begin
                for (int i = 0; i < int'(BUF_WORDS); i++) begin
                  if (int'(r_cnt[4:2]) == i) w_rx[i][{r_cnt[1:0], 3'b000} +: 8] = spi_rx_data;
                end
                w_cnt = w_cnt_inc;
              end
              w_nxt = next_byte_state(r_state, r_cmd[8], w_more);
              if (w_nxt == S_CS_HOLD) begin
                w_state = S_CS_HOLD;
              end else begin
                w_state     = w_nxt;
                w_phase     = PH_PULSE;
                w_spi_start = 1'b1;
                w_spi_tx    = tx_byte(w_nxt, r_cmd[7:0], r_addr);
              end
            end
          end
        endcase
      end
      S_CS_HOLD: begin
        w_spi_cs = 1'b1;
        w_busy   = 1'b0;
        w_done   = 1'b1;
        w_state  = S_IDLE;
      end
      default: begin
        w_spi_cs = 1'b1;
        w_state  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_PULSE;
      r_spi_cs    <= 1'b1;
      r_spi_start <= 1'b0;
      r_spi_tx    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < int'(BUF_WORDS); i++) r_rx[i] <= '0;
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_spi_cs    <= w_spi_cs;
      r_spi_start <= w_spi_start;
      r_spi_tx    <= w_spi_tx;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_cmd       <= w_cmd;
      r_addr      <= w_addr;
      r_len       <= w_len;
      r_cnt       <= w_cnt;
      for (int i = 0; i < int'(BUF_WORDS); i++) r_rx[i] <= w_rx[i];
    end
  end

  // Zero-wait-state register read mux; RX words are hidden in application mode
  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      case (address)
        REG_STATUS: begin
          read_data[ST_BUSY_BIT] = r_busy;
          read_data[ST_DONE_BIT] = r_done;
          read_data[ST_ERR_BIT]  = r_err;
        end
        REG_CMD:  read_data = DATA_W'(r_cmd);
        REG_ADDR: read_data = DATA_W'(r_addr);
        REG_LEN:  read_data = DATA_W'(r_len);
        default: ;
      endcase
      if (!fw_app_mode) begin
        for (int i = 0; i < int'(BUF_WORDS); i++) begin
          if (address == 8'(int'(REG_RX_BASE) + i)) read_data = r_rx[i];
        end
      end
    end
  end

  assign ready       = cs;
  assign spi_cs      = r_spi_cs;
  assign spi_start   = r_spi_start;
  assign spi_tx_data = r_spi_tx;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed + randomized bench for spi_flash_seq with a behavioural SPI byte
// engine and a transaction-level expectation model.
module tb_spi_flash_seq;
  import tk1_pkg::*;

  localparam int unsigned BUF_WORDS = 4;

  logic        clk = 1'b0, reset_n = 1'b0, fw_app_mode = 1'b0, cs = 1'b0, we = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready, spi_start, spi_cs;
  logic [7:0]  spi_tx_data;
  logic [7:0]  spi_rx_data = '0;
  logic        spi_ready = 1'b1;

  always #5 clk = ~clk;

  spi_flash_seq #(.BUF_WORDS(BUF_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .fw_app_mode(fw_app_mode), .cs(cs), .we(we),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data),
    .spi_ready(spi_ready), .spi_cs(spi_cs)
  );

  // Byte engine: random byte time, returns pre-planned receive bytes
  logic [7:0] tx_log [$];
  logic [7:0] rx_plan [256];
  int         n_done = 0, eng_cnt = 0, eng_lat_max = 3;

  always @(posedge clk) begin
    if (!reset_n) begin
      spi_ready <= 1'b1;
      eng_cnt   <= 0;
    end else if (spi_start) begin
      tx_log.push_back(spi_tx_data);
      spi_ready <= 1'b0;
      eng_cnt   <= $urandom_range(eng_lat_max, 1);
    end else if (eng_cnt == 1) begin
      spi_ready   <= 1'b1;
      spi_rx_data <= rx_plan[n_done[7:0]];
      n_done      <= n_done + 1;
      eng_cnt     <= 0;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  // Bus-side event monitor, sampled mid-cycle
  int   cyc = 0, cs_fall_cyc = 0, first_start_cyc = -1, cs_rise_cyc = 0, last_done_cyc = 0;
  int   n_cs_fall = 0, viol = 0;
  logic prev_cs = 1'b1, prev_ready = 1'b1, prev_start = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !spi_cs) begin cs_fall_cyc = cyc; first_start_cyc = -1; n_cs_fall++; end
    if (!prev_cs && spi_cs) cs_rise_cyc = cyc;
    if (spi_ready && !prev_ready) last_done_cyc = cyc;
    if (spi_start) begin
      if (first_start_cyc < 0) first_start_cyc = cyc;
      if (spi_cs || !spi_ready || prev_start) viol++;
    end
    prev_cs = spi_cs; prev_ready = spi_ready; prev_start = spi_start;
  end

  int n_checks = 0, n_pass = 0;
  int cur_tx0 = 0, cur_d0 = 0, cur_fall0 = 0;
  logic [31:0] last_words [BUF_WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk); cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b0; address = a;
    #1 d = read_data;
    cs = 1'b0; address = '0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int g = 0;
    do begin bus_read(REG_STATUS, s); g++; end while (s[0] && g < 1000);
    check({tag, "_timeout"}, 32'(g < 1000), 32'd1);
  endtask

  task automatic txn_setup(input logic [8:0] cmd, input logic [23:0] fa, input int len,
                           input bit fixed);
    int hdr;
    bus_write(REG_CMD, 32'(cmd));
    bus_write(REG_ADDR, 32'(fa));
    bus_write(REG_LEN, 32'(len));
    cur_tx0 = tx_log.size(); cur_d0 = n_done; cur_fall0 = n_cs_fall;
    hdr = cmd[8] ? 4 : 1;
    for (int k = 0; k < 40; k++) rx_plan[8'(cur_d0 + k)] = 8'($urandom);
    if (fixed) for (int i = 0; i < len; i++) rx_plan[8'(cur_d0 + hdr + i)] = 8'(8'hA1 + i);
  endtask

  // Expected transaction from the command fields alone
  task automatic txn_check(input string tag, input logic [8:0] cmd, input logic [23:0] fa,
                           input int len);
    logic [7:0]  exp_q [$];
    logic [31:0] exp_w [BUF_WORDS];
    int hdr;
    exp_q.push_back(cmd[7:0]);
    if (cmd[8]) begin exp_q.push_back(fa[23:16]); exp_q.push_back(fa[15:8]); exp_q.push_back(fa[7:0]); end
    repeat (len) exp_q.push_back(8'h00);
    check({tag, "_ntx"}, 32'(tx_log.size() - cur_tx0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (cur_tx0 + i < tx_log.size())
        check($sformatf("%s_tx%0d", tag, i), 32'(tx_log[cur_tx0 + i]), 32'(exp_q[i]));
    hdr = cmd[8] ? 4 : 1;
    for (int w = 0; w < BUF_WORDS; w++) exp_w[w] = '0;
    for (int i = 0; i < len; i++)
      exp_w[i / 4] |= 32'(rx_plan[8'(cur_d0 + hdr + i)]) << (8 * (i % 4));
    for (int w = 0; w < BUF_WORDS; w++) begin
      rd_check($sformatf("%s_rx%0d", tag, w), 8'(16 + w), exp_w[w]);
      last_words[w] = exp_w[w];
    end
    rd_check({tag, "_status"}, REG_STATUS, 32'h2);
    check({tag, "_cs_idle"}, 32'(spi_cs), 32'd1);
    check({tag, "_one_cs"}, 32'(n_cs_fall - cur_fall0), 32'd1);
    check({tag, "_setup"}, 32'(first_start_cyc - cs_fall_cyc), 32'd1);
    check({tag, "_hold"}, 32'(cs_rise_cyc - last_done_cyc), 32'd2);
  endtask

  task automatic run_txn(input string tag, input logic [8:0] cmd, input logic [23:0] fa,
                         input int len, input bit fixed);
    txn_setup(cmd, fa, len, fixed);
    bus_write(REG_CTRL, 32'h1);
    wait_idle(tag);
    txn_check(tag, cmd, fa, len);
  endtask

  initial begin
    logic [31:0] d;
    int g;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state and bus basics
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_tx", 32'(spi_tx_data), 32'd0);
    rd_check("rst_status", REG_STATUS, 32'h0);
    rd_check("rst_cmd", REG_CMD, 32'h0);
    rd_check("rst_addr", REG_ADDR, 32'h0);
    rd_check("rst_len", REG_LEN, 32'h0);
    rd_check("rst_rx0", REG_RX_BASE, 32'h0);
    rd_check("unmapped", 8'h20, 32'h0);
    check("ready_idle", 32'(ready), 32'd0);
    @(negedge clk); cs = 1'b1; we = 1'b1; address = REG_CMD; write_data = 32'h55;
    #1 check("ready_cs", 32'(ready), 32'd1);
    check("rdata_on_write", read_data, 32'h0);
    @(negedge clk); cs = 1'b0; we = 1'b0;
    rd_check("cmd_rb", REG_CMD, 32'h55);

    run_txn("wren", 9'h006, 24'h0, 0, 1'b0);
    run_txn("read5", 9'h103, 24'h012345, 5, 1'b1);
    check("read5_w0", last_words[0], 32'hA4A3A2A1);
    check("read5_w1", last_words[1], 32'h000000A5);

    // Application mode blocks writes and hides RX
    fw_app_mode = 1'b1;
    cur_tx0 = tx_log.size();
    bus_write(REG_LEN, 32'h3);
    bus_write(REG_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    check("app_no_tx", 32'(tx_log.size() - cur_tx0), 32'd0);
    check("app_cs", 32'(spi_cs), 32'd1);
    rd_check("app_rx0", REG_RX_BASE, 32'h0);
    rd_check("app_rx1", REG_RX_BASE + 8'h1, 32'h0);
    rd_check("app_len", REG_LEN, 32'h5);
    fw_app_mode = 1'b0;
    rd_check("noapp_rx0", REG_RX_BASE, 32'hA4A3A2A1);

    // Over-length start is an error with no bus activity
    cur_tx0 = tx_log.size(); cur_fall0 = n_cs_fall;
    bus_write(REG_LEN, 32'd17);
    bus_write(REG_CTRL, 32'h1);
    rd_check("err_status", REG_STATUS, 32'h6);
    repeat (4) @(negedge clk);
    check("err_no_tx", 32'(tx_log.size() - cur_tx0), 32'd0);
    check("err_no_cs", 32'(n_cs_fall - cur_fall0), 32'd0);
    check("err_cs", 32'(spi_cs), 32'd1);

    // Writes while busy are dropped
    eng_lat_max = 2;
    txn_setup(9'h103, 24'h0ABCDE, 6, 1'b0);
    bus_write(REG_CTRL, 32'h1);
    bus_write(REG_ADDR, 32'hFFFFFF);
    bus_write(REG_CTRL, 32'h1);
    bus_write(REG_LEN, 32'd2);
    bus_write(REG_CMD, 32'h0AB);
    wait_idle("busy");
    txn_check("busy", 9'h103, 24'h0ABCDE, 6);
    rd_check("busy_addr", REG_ADDR, 32'h0ABCDE);
    rd_check("busy_len", REG_LEN, 32'd6);
    rd_check("busy_cmd", REG_CMD, 32'h103);

    // Start landing on the edge where busy falls is ignored
    eng_lat_max = 1;
    txn_setup(9'h006, 24'h0, 0, 1'b0);
    bus_write(REG_CTRL, 32'h1);
    g = 0;
    do begin @(negedge clk); g++; end
    while (!(tx_log.size() == cur_tx0 + 1 && !spi_start && spi_ready) && g < 200);
    check("fall_timeout", 32'(g < 200), 32'd1);
    @(negedge clk);
    check("hold_cs_low", 32'(spi_cs), 32'd0);
    cs = 1'b1; we = 1'b1; address = REG_CTRL; write_data = 32'h1;
    @(negedge clk); cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    repeat (6) @(negedge clk);
    check("fall_ntx", 32'(tx_log.size() - cur_tx0), 32'd1);
    check("fall_cs", 32'(spi_cs), 32'd1);
    rd_check("fall_status", REG_STATUS, 32'h2);

    // Boundary lengths and randomized commands
    eng_lat_max = 4;
    run_txn("len16", 9'h10B, 24'hFEDCBA, 16, 1'b0);
    run_txn("noaddr_len3", 9'h09F, 24'h0, 3, 1'b0);
    run_txn("addr_len0", 9'h1D8, 24'h123456, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      eng_lat_max = $urandom_range(5, 1);
      run_txn($sformatf("rnd%0d", t), 9'($urandom), 24'($urandom), $urandom_range(16, 0), 1'b0);
    end

    // Reset in the middle of the third read byte
    eng_lat_max = 3;
    txn_setup(9'h003, 24'h0, 8, 1'b0);
    bus_write(REG_CTRL, 32'h1);
    g = 0;
    do begin @(negedge clk); g++; end while (tx_log.size() < cur_tx0 + 4 && g < 300);
    check("rst_mid_timeout", 32'(g < 300), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_cs", 32'(spi_cs), 32'd1);
    check("rst_mid_start", 32'(spi_start), 32'd0);
    reset_n = 1'b1;
    rd_check("rst_mid_status", REG_STATUS, 32'h0);
    rd_check("rst_mid_rx0", REG_RX_BASE, 32'h0);
    rd_check("rst_mid_len", REG_LEN, 32'h0);
    repeat (10) @(negedge clk);
    check("rst_mid_quiet", 32'(spi_cs), 32'd1);

    check("protocol_viol", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_flash_seq.md
SPI_FLASH_SEQ -- requirements
Module: spi_flash_seq

Interface
REQ-001 SHALL have parameter BUF_WORDS, default 4: number of 32-bit RX buffer words; maximum read length is 4*BUF_WORDS bytes.
REQ-002 SHALL have port clk, input, 1: clock.
REQ-003 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port fw_app_mode, input, 1: 1 = application mode.
REQ-005 SHALL have port cs, input, 1: API select.
REQ-006 SHALL have port we, input, 1: API write enable.
REQ-007 SHALL have port address, input, 8: API register address.
REQ-008 SHALL have port write_data, input, 32: API write data.
REQ-009 SHALL have port read_data, output, 32: API read data.
REQ-010 SHALL have port ready, output, 1: API ready.
REQ-011 SHALL have port spi_start, output, 1: one-cycle byte-start pulse to the byte engine.
REQ-012 SHALL have port spi_tx_data, output, 8: byte to shift out.
REQ-013 SHALL have port spi_rx_data, input, 8: byte shifted in.
REQ-014 SHALL have port spi_ready, input, 1: byte engine idle.
REQ-015 SHALL have port spi_cs, output, 1: flash chip select; 1 = deselected.

Function
REQ-016 SHALL implement this register map. 0x00 CTRL: write bit0=1 starts a transaction. 0x01 STATUS: read-only; bit0 busy, bit1 done, bit2 err. 0x02 CMD: [7:0] opcode, [8] addr_en. 0x03 ADDR: [23:0] flash address. 0x04 LEN: [4:0] receive byte count. 0x10..0x10+BUF_WORDS-1: RX words, read-only.
REQ-017 SHALL assert ready combinationally whenever cs=1, with zero wait states.
REQ-018 SHALL drive read_data to 0 for unmapped addresses, write cycles, and cs=0.
REQ-019 SHALL ignore every API write while fw_app_mode=1; in that mode RX words SHALL read as 0.
REQ-020 SHALL ignore writes to CMD, ADDR, LEN and CTRL while busy=1.
REQ-021 SHALL treat a start with LEN > 4*BUF_WORDS as an error: set err=1 and done=1, leave spi_cs at 1, issue no spi_start.
REQ-022 On a valid start, SHALL clear the RX buffer, done and err, set busy=1, and enter CS_SETUP.
REQ-023 State machine: IDLE -> CS_SETUP -> OPCODE -> ADDR2 -> ADDR1 -> ADDR0 -> READ -> CS_HOLD -> IDLE.
REQ-024 The address states SHALL be skipped when addr_en=0.
REQ-025 READ SHALL be skipped when LEN=0, so an opcode-only command (e.g. 0x06) is legal.
REQ-026 CS_SETUP SHALL drive spi_cs=0 for exactly one cycle before the first spi_start.
REQ-027 spi_cs SHALL stay 0 from CS_SETUP through the end of CS_HOLD.
REQ-028 Byte handshake: SHALL pulse spi_start for one cycle only when spi_ready=1, with spi_tx_data valid in the same cycle.
REQ-029 SHALL ignore spi_ready in the cycle after spi_start, then wait for spi_ready=1, which marks byte completion.
REQ-030 Byte order SHALL be opcode first, then ADDR[23:16], ADDR[15:8], ADDR[7:0].
REQ-031 In READ, spi_tx_data SHALL be 0x00.
REQ-032 In READ, on completion of byte i (0-based), spi_rx_data SHALL be stored to word i/4, bits [8*(i%4)+7 : 8*(i%4)].
REQ-033 A 5-bit byte counter SHALL count up to LEN with no wrap; READ exits when counter = LEN.
REQ-034 CS_HOLD SHALL last one cycle with spi_cs=0, then drive spi_cs=1.
REQ-035 On return to IDLE, SHALL set busy=0 and done=1.
REQ-036 done SHALL stay set until the next accepted start.
REQ-037 Minimum latency for opcode-only SHALL be 1 cycle (CS_SETUP) + byte time + 1 cycle (CS_HOLD).
REQ-038 A start write in the same cycle that busy falls SHALL be ignored; busy is evaluated on the registered value.

Reset
REQ-039 On reset_n=0 at a clock edge, SHALL load: state IDLE, spi_cs=1, spi_start=0, spi_tx_data=0, busy=0, done=0, err=0, CMD=0, ADDR=0, LEN=0, RX buffer=0, byte counter=0.
REQ-040 Reset mid-transaction SHALL deselect the flash (spi_cs=1) at that edge and abandon the transfer.

Structure
REQ-041 Register addresses, STATUS bit positions and state encodings SHALL live in a shared package, tk1_pkg.
REQ-042 The block SHALL be a single module with no sub-modules; it sequences the existing SPI byte engine.

Verification
REQ-043 CMD=0x006, LEN=0, start -> exactly one spi_start with tx 0x06; spi_cs low for CS_SETUP+byte+CS_HOLD; STATUS reads 0x2.
REQ-044 CMD=0x103, ADDR=0x012345, LEN=5, engine returns 0xA1..0xA5 -> tx bytes 03,01,23,45,00x5; RX word0=0xA4A3A2A1, word1=0x000000A5.
REQ-045 LEN=17 with BUF_WORDS=4, start -> STATUS=0x6, spi_cs stays 1, no spi_start.
REQ-046 Write ADDR=0xFFFFFF and a second start while busy -> ADDR and transfer unchanged; a single transaction completes.
REQ-047 fw_app_mode=1, write CTRL=1 -> no transaction; RX words read 0.
REQ-048 reset_n=0 during READ byte 2 -> next cycle spi_cs=1, STATUS=0, RX words=0.
